benes_stage_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 8-port, 4-bit Benes stage.
- N_PORTS ports of DATA_W bits each, routed through N_PORTS/2 2x2 switches. Each switch is straight or cross.
- Adds double-buffered switch configuration that commits atomically, plus a ready/valid output register stage, so stages can be chained into a full stallable Benes network.

---
 rtl/benes_stage_pipe.sv | 138 +++++++++++++
 tb/tb_benes_stage_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/benes_stage_pipe.sv
// benes_stage_pipe
// One pipelined stage of a Benes network. The N_PORTS input words are routed
// through N_PORTS/2 2x2 switches. Each switch is either straight or cross. The
// routed vector is then captured in a ready/valid output register. The switch
// configuration is double-buffered: writes go to a shadow register, and a
// commit copies the shadow into the active set atomically. Stages can therefore
// be chained into a stallable network and reconfigured between vectors.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-high reset
//   i_port       input word per port (unpacked array of N_PORTS words)
//   i_valid      i_port holds a valid vector
//   i_ready      stage accepts the vector this cycle
//   o_port       registered routed vector
//   o_valid      o_port valid
//   o_ready      downstream accepts o_port
//   cfg_wr       load cfg_data into the shadow configuration
//   cfg_data     new switch settings, bit i controls switch i
//   cfg_commit   copy shadow into the active configuration
//   switch_set   active configuration
//   cfg_pending  shadow differs from active (written but not yet committed)

module benes_stage_pipe #(
  parameter  int N_PORTS = 8,
  parameter  int DATA_W  = 4,
  localparam int N_SW    = N_PORTS / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_port [N_PORTS],
  input  logic              i_valid,
  output logic              i_ready,
  output logic [DATA_W-1:0] o_port [N_PORTS],
  output logic              o_valid,
  input  logic              o_ready,
  input  logic              cfg_wr,
  input  logic [N_SW-1:0]   cfg_data,
  input  logic              cfg_commit,
  output logic [N_SW-1:0]   switch_set,
  output logic              cfg_pending
);

  logic [DATA_W-1:0] routed   [N_PORTS];
  logic [DATA_W-1:0] o_port_q [N_PORTS];
  logic [DATA_W-1:0] o_port_d [N_PORTS];
  logic              o_valid_q, o_valid_d;
  logic [N_SW-1:0]   active_q, active_d;
  logic [N_SW-1:0]   shadow_q, shadow_d;
  logic              cfg_pending_q, cfg_pending_d;
  logic              accept;

  // The ready signal depends only on registered state and o_ready. This keeps
  // any path from i_valid back to i_ready out of a chained network.
  assign i_ready = o_ready | ~o_valid_q;
  assign accept  = i_valid & i_ready;

  // Switch crossbar. The currently active configuration steers it, so a
  // vector accepted in a commit cycle still sees the old settings.
  always_comb begin
    for (int i = 0; i < N_SW; i++) begin
      if (active_q[i]) begin
        routed[2*i]   = i_port[2*i+1];
        routed[2*i+1] = i_port[2*i];
      end else begin
        routed[2*i]   = i_port[2*i];
        routed[2*i+1] = i_port[2*i+1];
      end
    end
  end

  // Output register. It loads only on accept. Otherwise it drains when the
  // downstream takes the word, and holds while stalled.
  always_comb begin
    o_port_d  = o_port_q;
    o_valid_d = o_valid_q;
    if (accept) begin
      o_port_d  = routed;
      o_valid_d = 1'b1;
    end else if (o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // Configuration double buffer. When a write and a commit occur together,
  // the new data goes straight through to the active set.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (cfg_wr) begin
      shadow_d = cfg_data;
    end
    if (cfg_commit) begin
      active_d = cfg_wr ? cfg_data : shadow_q;
    end
    cfg_pending_d = (shadow_d != active_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_PORTS; k++) begin
        o_port_q[k] <= '0;
      end
      o_valid_q     <= 1'b0;
      active_q      <= '0;
      shadow_q      <= '0;
      cfg_pending_q <= 1'b0;
    end else begin
      o_port_q      <= o_port_d;
      o_valid_q     <= o_valid_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      cfg_pending_q <= cfg_pending_d;
    end
  end

  assign o_port      = o_port_q;
  assign o_valid     = o_valid_q;
  assign switch_set  = active_q;
  assign cfg_pending = cfg_pending_q;

  // Simulation-only checks.
  if ((N_PORTS < 2) || ((N_PORTS % 2) != 0)) begin : g_param_check
    $error("benes_stage_pipe: N_PORTS must be even and >= 2");
  end

  // Flat copy of the output register. It lets the stall check use $stable.
  logic [N_PORTS*DATA_W-1:0] o_port_flat;
  always_comb begin
    for (int k = 0; k < N_PORTS; k++) begin
      o_port_flat[k*DATA_W +: DATA_W] = o_port_q[k];
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (o_valid_q && !o_ready) |=> ($stable(o_port_flat) && o_valid_q));

endmodule

// File: tb/tb_benes_stage_pipe.sv
// tb_benes_stage_pipe
// Directed, table-driven checks on an 8-port/4-bit stage. Each table row holds
// one cycle of inputs and the outputs expected just after that clock edge.
// A short hand-written sequence exercises the 2-port boundary. A 16-port/8-bit
// stage is then run with random traffic, random reconfiguration and random
// resets, and is compared against a cycle-level reference model.

module tb_benes_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- 8-port, 4-bit instance ----------------
  logic       a_rst, a_iv, a_irdy, a_ov, a_ordy, a_wr, a_cm, a_pend;
  logic [3:0] a_data, a_sw;
  logic [3:0] a_in  [8];
  logic [3:0] a_out [8];

  benes_stage_pipe #(.N_PORTS(8), .DATA_W(4)) dut_a (
    .clk(clk), .rst(a_rst), .i_port(a_in), .i_valid(a_iv), .i_ready(a_irdy),
    .o_port(a_out), .o_valid(a_ov), .o_ready(a_ordy), .cfg_wr(a_wr),
    .cfg_data(a_data), .cfg_commit(a_cm), .switch_set(a_sw), .cfg_pending(a_pend)
  );

  // ---------------- 2-port, 4-bit instance ----------------
  logic       c_rst, c_iv, c_irdy, c_ov, c_ordy, c_wr, c_cm, c_pend;
  logic [0:0] c_data, c_sw;
  logic [3:0] c_in  [2];
  logic [3:0] c_out [2];

  benes_stage_pipe #(.N_PORTS(2), .DATA_W(4)) dut_c (
    .clk(clk), .rst(c_rst), .i_port(c_in), .i_valid(c_iv), .i_ready(c_irdy),
    .o_port(c_out), .o_valid(c_ov), .o_ready(c_ordy), .cfg_wr(c_wr),
    .cfg_data(c_data), .cfg_commit(c_cm), .switch_set(c_sw), .cfg_pending(c_pend)
  );

  // ---------------- 16-port, 8-bit instance ----------------
  logic       b_rst, b_iv, b_irdy, b_ov, b_ordy, b_wr, b_cm, b_pend;
  logic [7:0] b_data, b_sw;
  logic [7:0] b_in  [16];
  logic [7:0] b_out [16];

  benes_stage_pipe #(.N_PORTS(16), .DATA_W(8)) dut_b (
    .clk(clk), .rst(b_rst), .i_port(b_in), .i_valid(b_iv), .i_ready(b_irdy),
    .o_port(b_out), .o_valid(b_ov), .o_ready(b_ordy), .cfg_wr(b_wr),
    .cfg_data(b_data), .cfg_commit(b_cm), .switch_set(b_sw), .cfg_pending(b_pend)
  );

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic        ordy;
    logic        wr;
    logic        cm;
    logic [3:0]  data;
    logic [31:0] din;
    logic        e_ov;
    logic [31:0] e_out;
    logic [3:0]  e_sw;
    logic        e_pend;
    logic        e_irdy;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] flatA();
    logic [31:0] f;
    for (int k = 0; k < 8; k++) f[4*k +: 4] = a_out[k];
    return f;
  endfunction

  function automatic logic [127:0] flatB();
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[8*k +: 8] = b_out[k];
    return f;
  endfunction

  // Reference routing: output port p takes input port p with its low bit
  // flipped whenever the switch owning p is set.
  function automatic logic [127:0] route16(input logic [127:0] d, input logic [7:0] sel);
    logic [127:0] r;
    int src;
    for (int p = 0; p < 16; p++) begin
      src = sel[p/2] ? (p ^ 1) : p;
      r[8*p +: 8] = d[8*src +: 8];
    end
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    a_rst  = v.rst;
    a_iv   = v.iv;
    a_ordy = v.ordy;
    a_wr   = v.wr;
    a_cm   = v.cm;
    a_data = v.data;
    for (int k = 0; k < 8; k++) a_in[k] = v.din[4*k +: 4];
    @(posedge clk);
    #1;
  endtask

  logic [127:0] m_port;
  logic         m_ov, m_pend, m_acc;
  logic [7:0]   m_act, m_sh;
  logic [127:0] b_din;

  initial begin
    a_rst = 1'b1; a_iv = 1'b0; a_ordy = 1'b0; a_wr = 1'b0; a_cm = 1'b0; a_data = '0;
    c_rst = 1'b1; c_iv = 1'b0; c_ordy = 1'b0; c_wr = 1'b0; c_cm = 1'b0; c_data = '0;
    b_rst = 1'b1; b_iv = 1'b0; b_ordy = 1'b0; b_wr = 1'b0; b_cm = 1'b0; b_data = '0;
    for (int k = 0; k < 8; k++)  a_in[k] = '0;
    for (int k = 0; k < 2; k++)  c_in[k] = '0;
    for (int k = 0; k < 16; k++) b_in[k] = '0;

    // Row layout: rst iv ordy wr cm data din | ov out sw pend irdy
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,32'h0,        1'b0,32'h0,        4'h0,1'b0,1'b1};
    vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,4'h0,32'h76543210, 1'b1,32'h76543210, 4'h0,1'b0,1'b1};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,4'h5,32'h0,        1'b0,32'h76543210, 4'h0,1'b1,1'b1};
    vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,4'h0,32'h76543210, 1'b1,32'h76543210, 4'h5,1'b0,1'b1};
    vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,4'h0,32'h76543210, 1'b1,32'h76453201, 4'h5,1'b0,1'b1};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,32'hFEDCBA98, 1'b1,32'h76453201, 4'h5,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,32'hFEDCBA98, 1'b1,32'h76453201, 4'h5,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,32'hFEDCBA98, 1'b1,32'h76453201, 4'h5,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,4'h0,32'hFEDCBA98, 1'b1,32'hFECDBA89, 4'h5,1'b0,1'b1};
    vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,4'h0,32'h0,        1'b0,32'hFECDBA89, 4'h5,1'b0,1'b1};
    vecs[10] = '{1'b0,1'b0,1'b1,1'b1,1'b0,4'h3,32'h0,        1'b0,32'hFECDBA89, 4'h5,1'b1,1'b1};
    vecs[11] = '{1'b0,1'b0,1'b1,1'b1,1'b1,4'h8,32'h0,        1'b0,32'hFECDBA89, 4'h8,1'b0,1'b1};
    vecs[12] = '{1'b0,1'b0,1'b1,1'b0,1'b1,4'hF,32'h0,        1'b0,32'hFECDBA89, 4'h8,1'b0,1'b1};
    vecs[13] = '{1'b0,1'b0,1'b1,1'b1,1'b1,4'hF,32'h0,        1'b0,32'hFECDBA89, 4'hF,1'b0,1'b1};
    vecs[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,32'h76543210, 1'b1,32'h67452301, 4'hF,1'b0,1'b0};
    vecs[15] = '{1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,32'h13572468, 1'b1,32'h67452301, 4'hF,1'b0,1'b0};
    vecs[16] = '{1'b1,1'b1,1'b0,1'b1,1'b1,4'h6,32'h13572468, 1'b0,32'h0,        4'h0,1'b0,1'b1};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,32'h0,        1'b0,32'h0,        4'h0,1'b0,1'b1};

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d_o_valid", i), {127'd0, a_ov},   {127'd0, vecs[i].e_ov});
      checkOutput($sformatf("row%0d_o_port", i),  {96'd0, flatA()}, {96'd0, vecs[i].e_out});
      checkOutput($sformatf("row%0d_switch", i),  {124'd0, a_sw},   {124'd0, vecs[i].e_sw});
      checkOutput($sformatf("row%0d_pending", i), {127'd0, a_pend}, {127'd0, vecs[i].e_pend});
      checkOutput($sformatf("row%0d_i_ready", i), {127'd0, a_irdy}, {127'd0, vecs[i].e_irdy});
    end
    a_rst = 1'b1;

    // Two-port stage: a single switch, first straight and then crossed.
    c_rst = 1'b0; c_ordy = 1'b1; c_iv = 1'b1; c_in[0] = 4'h5; c_in[1] = 4'hA;
    @(posedge clk); #1;
    checkOutput("p2_straight", {120'd0, c_out[1], c_out[0]}, {120'd0, 8'hA5});
    checkOutput("p2_valid", {127'd0, c_ov}, 128'd1);
    c_iv = 1'b0; c_wr = 1'b1; c_data = 1'b1; c_cm = 1'b1;
    @(posedge clk); #1;
    checkOutput("p2_switch", {127'd0, c_sw}, 128'd1);
    checkOutput("p2_drain", {127'd0, c_ov}, 128'd0);
    c_wr = 1'b0; c_cm = 1'b0; c_iv = 1'b1;
    @(posedge clk); #1;
    checkOutput("p2_cross", {120'd0, c_out[1], c_out[0]}, {120'd0, 8'h5A});
    c_iv = 1'b0; c_rst = 1'b1;

    // 16-port stage with random traffic against the reference model.
    m_port = '0; m_ov = 1'b0; m_act = '0; m_sh = '0; m_pend = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      b_rst  = (cyc == 0) || ($urandom_range(0, 39) == 0);
      b_iv   = $urandom_range(0, 3) != 0;
      b_ordy = $urandom_range(0, 2) != 0;
      b_wr   = $urandom_range(0, 5) == 0;
      b_cm   = $urandom_range(0, 5) == 0;
      b_data = 8'($urandom);
      for (int k = 0; k < 16; k++) begin
        b_in[k] = 8'($urandom);
        b_din[8*k +: 8] = b_in[k];
      end

      m_acc = b_iv && (b_ordy || !m_ov);
      if (b_rst) begin
        m_port = '0; m_ov = 1'b0; m_act = '0; m_sh = '0;
      end else begin
        if (m_acc) begin
          m_port = route16(b_din, m_act);
          m_ov   = 1'b1;
        end else if (b_ordy) begin
          m_ov = 1'b0;
        end
        if (b_wr && b_cm) begin
          m_act = b_data;
          m_sh  = b_data;
        end else if (b_wr) begin
          m_sh = b_data;
        end else if (b_cm) begin
          m_act = m_sh;
        end
      end
      m_pend = (m_sh != m_act);

      @(posedge clk); #1;
      checkOutput($sformatf("rnd%0d_o_valid", cyc), {127'd0, b_ov}, {127'd0, m_ov});
      checkOutput($sformatf("rnd%0d_o_port", cyc), flatB(), m_port);
      checkOutput($sformatf("rnd%0d_switch", cyc), {120'd0, b_sw}, {120'd0, m_act});
      checkOutput($sformatf("rnd%0d_pending", cyc), {127'd0, b_pend}, {127'd0, m_pend});
      checkOutput($sformatf("rnd%0d_i_ready", cyc), {127'd0, b_irdy},
                  {127'd0, (b_ordy || !m_ov)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
